// File: rtl/cpu_pkg.sv
// Shared constants for the lab CPU control path: ALU codes, instruction
// fields, datapath select encodings and the multi-cycle controller states.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_BRANCH   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9
  } state_t;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational R-type funct to ALU operation map with a legal flag;
// kept standalone so pipelined control can reuse it.
module alu_funct_dec
  import cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  // Unsupported funct codes fall back to ADD and flag illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit: steps each instruction through fetch, decode,
// execute, memory and write-back, driving the ALU code and datapath controls.
module alu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic [3:0] alu_ctrl_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       iord_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_src_o,
  output logic       reg_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o
);

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] op_r;
  logic [5:0] funct_r;
  logic [3:0] dec_alu_s;
  logic       dec_legal_s;

  logic [3:0] alu_ctrl_s;
  logic       src_a_s;
  logic [1:0] src_b_s;
  logic       iord_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic       pc_src_s;
  logic       reg_we_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       illegal_s;

  alu_funct_dec u_funct_dec (
    .funct    (funct_r),
    .alu_ctrl (dec_alu_s),
    .legal    (dec_legal_s)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction fields are latched in DECODE; later states must not see IR reloads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_r    <= 6'd0;
      funct_r <= 6'd0;
    end else if (state_r == S_DECODE) begin
      op_r    <= opcode_i;
      funct_r <= funct_i;
    end else begin
      op_r    <= op_r;
      funct_r <= funct_r;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    next_state_s = state_r;
    alu_ctrl_s   = ALU_ADD;
    src_a_s      = 1'b0;
    src_b_s      = SRC_B_RT;
    iord_s       = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    pc_src_s     = 1'b0;
    reg_we_s     = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        src_b_s      = SRC_B_FOUR;
        ir_we_s      = mem_ack_i;
        pc_we_s      = mem_ack_i;
        next_state_s = mem_ack_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut picks up PC + (imm << 2) as the speculative branch target
        src_b_s = SRC_B_IMM_SH;
        case (opcode_i)
          OP_RTYPE:        next_state_s = S_EXEC_R;
          OP_ADDI, OP_SLTI: next_state_s = S_EXEC_I;
          OP_BEQ, OP_BNE:  next_state_s = S_BRANCH;
          OP_LW, OP_SW:    next_state_s = S_MEM_ADDR;
          default: begin
            next_state_s = S_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        src_a_s    = 1'b1;
        alu_ctrl_s = dec_alu_s;
        if (dec_legal_s) begin
          reg_dst_s    = 1'b1;
          next_state_s = S_WB_ALU;
        end else begin
          illegal_s    = 1'b1;
          next_state_s = S_FETCH;
        end
      end
      S_EXEC_I: begin
        src_a_s      = 1'b1;
        src_b_s      = SRC_B_IMM;
        alu_ctrl_s   = (op_r == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state_s = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we_s     = 1'b1;
        reg_dst_s    = (op_r == OP_RTYPE);
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s      = 1'b1;
        alu_ctrl_s   = ALU_SUB;
        pc_src_s     = 1'b1;
        pc_we_s      = (op_r == OP_BNE) ? ~zero_i : zero_i;
        next_state_s = S_FETCH;
      end
      S_MEM_ADDR: begin
        src_a_s      = 1'b1;
        src_b_s      = SRC_B_IMM;
        next_state_s = (op_r == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_s    = 1'b1;
        iord_s       = 1'b1;
        next_state_s = mem_ack_i ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_req_s    = 1'b1;
        mem_we_s     = 1'b1;
        iord_s       = 1'b1;
        next_state_s = mem_ack_i ? S_FETCH : S_MEM_WR;
      end
      S_WB_MEM: begin
        reg_we_s     = 1'b1;
        mem_to_reg_s = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Reset masks every request/enable at once so an in-flight access is dropped
  assign alu_ctrl_o   = rst_i ? ALU_ADD : alu_ctrl_s;
  assign alu_src_a_o  = src_a_s;
  assign alu_src_b_o  = src_b_s;
  assign iord_o       = iord_s & ~rst_i;
  assign mem_req_o    = mem_req_s & ~rst_i;
  assign mem_we_o     = mem_we_s & ~rst_i;
  assign ir_we_o      = ir_we_s & ~rst_i;
  assign pc_we_o      = pc_we_s & ~rst_i;
  assign pc_src_o     = pc_src_s;
  assign reg_we_o     = reg_we_s & ~rst_i;
  assign reg_dst_o    = reg_dst_s;
  assign mem_to_reg_o = mem_to_reg_s;
  assign illegal_o    = illegal_s & ~rst_i;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm with hand-computed expectations.
module tb_alu_ctrl_fsm;
  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;
  logic [3:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       pc_src;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  alu_ctrl_fsm dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .zero_i       (zero),
    .mem_ack_i    (mem_ack),
    .alu_ctrl_o   (alu_ctrl),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .iord_o       (iord),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .reg_we_o     (reg_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .illegal_o    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change at +2, checks happen at +3
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // FETCH with `waits` withheld-ack cycles; leaves the FSM in DECODE
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
    t0 = cyc;
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      #1;
      check("fetch_wait_req", mem_req, 1);
      check("fetch_wait_iord", iord, 0);
      check("fetch_wait_irwe", ir_we, 0);
      step();
    end
    mem_ack = 1'b1;
    opcode  = op;
    funct   = fn;
    #1;
    check("fetch_req", mem_req, 1);
    check("fetch_irwe", ir_we, 1);
    check("fetch_pcwe", pc_we, 1);
    check("fetch_srcb", alu_src_b, 1);
    check("fetch_alu", alu_ctrl, 2);
    step();
    mem_ack = 1'b0;
    #1;
    check("decode_srcb", alu_src_b, 3);
    check("decode_alu", alu_ctrl, 2);
    check("decode_req", mem_req, 0);
  endtask

  task automatic expect_fetch(input string tag, input int cycles);
    check({tag, "_fetch_req"}, mem_req, 1);
    check({tag, "_fetch_iord"}, iord, 0);
    check({tag, "_cycles"}, cyc - t0, cycles);
  endtask

  task automatic run_r(input logic [5:0] fn, input int exp_alu, input bit legal);
    do_fetch(6'd0, fn, 0);
    check("r_dec_illegal", illegal, 0);
    step();
    opcode = 6'd63;  // IR scrambled: FSM must use its captured copy
    funct  = 6'd13;
    #1;
    check("r_exec_srca", alu_src_a, 1);
    check("r_exec_srcb", alu_src_b, 0);
    if (legal) begin
      check("r_exec_alu", alu_ctrl, exp_alu);
      check("r_exec_illegal", illegal, 0);
      step();
      #1;
      check("r_wb_regwe", reg_we, 1);
      check("r_wb_regdst", reg_dst, 1);
      check("r_wb_memtoreg", mem_to_reg, 0);
      step();
      #1;
      expect_fetch("r", 4);
    end else begin
      check("r_bad_illegal", illegal, 1);
      check("r_bad_regwe", reg_we, 0);
      step();
      #1;
      check("r_bad_illegal_off", illegal, 0);
      check("r_bad_regwe_off", reg_we, 0);
      expect_fetch("r_bad", 3);
    end
  endtask

  task automatic run_i(input logic [5:0] op, input int exp_alu);
    do_fetch(op, 6'd0, 0);
    step();
    opcode = 6'd0;
    #1;
    check("i_exec_alu", alu_ctrl, exp_alu);
    check("i_exec_srca", alu_src_a, 1);
    check("i_exec_srcb", alu_src_b, 2);
    step();
    #1;
    check("i_wb_regwe", reg_we, 1);
    check("i_wb_regdst", reg_dst, 0);
    step();
    #1;
    expect_fetch("i", 4);
  endtask

  task automatic run_br(input logic [5:0] op, input bit z, input int exp_pcwe);
    do_fetch(op, 6'd0, 0);
    step();
    zero = z;
    #1;
    check("br_alu", alu_ctrl, 6);
    check("br_pcsrc", pc_src, 1);
    check("br_pcwe", pc_we, exp_pcwe);
    zero = ~z;
    #1;
    check("br_pcwe_flip", pc_we, 1 - exp_pcwe);
    step();
    zero = 1'b0;
    #1;
    expect_fetch("br", 3);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ack = 1'b1;
    step();
    step();
    #1;
    check("rst_req", mem_req, 0);
    check("rst_irwe", ir_we, 0);
    check("rst_pcwe", pc_we, 0);
    check("rst_alu", alu_ctrl, 2);
    check("rst_illegal", illegal, 0);
    mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("rel_req", mem_req, 1);
    check("rel_iord", iord, 0);

    // R-type and invalid funct
    run_r(6'd34, 6, 1'b1);
    run_r(6'd39, 12, 1'b1);
    run_r(6'd42, 7, 1'b1);
    run_r(6'd32, 2, 1'b1);
    run_r(6'd36, 0, 1'b1);
    run_r(6'd37, 1, 1'b1);
    run_r(6'd13, 0, 1'b0);

    run_i(6'd8, 2);
    run_i(6'd10, 7);

    run_br(6'd4, 1'b1, 1);
    run_br(6'd5, 1'b1, 0);

    // lw with two wait cycles in FETCH and in MEM_RD
    do_fetch(6'd35, 6'd0, 2);
    mem_ack = 1'b1;  // ack outside a memory state must be ignored
    step();
    #1;
    check("lw_addr_alu", alu_ctrl, 2);
    check("lw_addr_srcb", alu_src_b, 2);
    check("lw_addr_req", mem_req, 0);
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      check("lw_rd_req", mem_req, 1);
      check("lw_rd_iord", iord, 1);
      check("lw_rd_we", mem_we, 0);
      check("lw_rd_regwe", reg_we, 0);
    end
    step();
    mem_ack = 1'b1;
    #1;
    check("lw_rd_ack_req", mem_req, 1);
    step();
    mem_ack = 1'b0;
    #1;
    check("lw_wb_regwe", reg_we, 1);
    check("lw_wb_memtoreg", mem_to_reg, 1);
    check("lw_wb_regdst", reg_dst, 0);
    step();
    #1;
    expect_fetch("lw", 9);

    // sw zero-wait
    do_fetch(6'd43, 6'd0, 0);
    check("sw_dec_we", mem_we, 0);
    step();
    #1;
    check("sw_addr_we", mem_we, 0);
    step();
    mem_ack = 1'b1;
    #1;
    check("sw_wr_req", mem_req, 1);
    check("sw_wr_we", mem_we, 1);
    check("sw_wr_iord", iord, 1);
    check("sw_wr_regwe", reg_we, 0);
    step();
    mem_ack = 1'b0;
    #1;
    check("sw_after_we", mem_we, 0);
    check("sw_after_regwe", reg_we, 0);
    expect_fetch("sw", 4);

    // Illegal opcode
    do_fetch(6'd63, 6'd0, 0);
    check("op63_illegal", illegal, 1);
    step();
    #1;
    check("op63_illegal_off", illegal, 0);
    expect_fetch("op63", 2);

    // Reset in the middle of a read with ack withheld
    do_fetch(6'd35, 6'd0, 0);
    step();
    step();
    #1;
    check("mid_rd_req", mem_req, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_iord", iord, 0);
    step();
    #1;
    check("mid_rst_hold_req", mem_req, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_req", mem_req, 1);
    check("mid_rel_iord", iord, 0);
    check("mid_rel_srcb", alu_src_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
